normalizer_seq: RTL and testbench

- Iterative normalizer, the inverse of the barrel shifter. The shifter takes an amount and produces a shifted word; this block takes a word and returns the left-shift amount that normalizes it, plus the normalized word.
- Used ahead of the shifter and by the FP/fixed-point datapath to align operands.
- Binary-search algorithm resolves one amount bit per clock.
- valid/ready handshake on input and output; one operation in flight.

---
 rtl/normalizer_seq.sv | 137 +++++++++++++
 tb/tb_normalizer_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalizer_seq.sv
// Iterative normalizer: finds the left-shift that normalizes a word (leading zeros
// or redundant sign bits) by binary search, one amount bit per clock.
module normalizer_seq #(
    parameter int unsigned DSIZE = 64,
    parameter int unsigned ASIZE = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [ASIZE-1:0] amount,
    output logic             zero
);

    localparam int unsigned KW = (ASIZE > 1) ? $clog2(ASIZE) : 1;
    localparam int unsigned LW = ASIZE + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DSIZE-1:0] work_q, work_d;
    logic [ASIZE-1:0] acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic             mode_q, mode_d;
    logic             ones_q, ones_d;
    logic             zero_q, zero_d;
    logic [DSIZE-1:0] out_data_q, out_data_d;
    logic [ASIZE-1:0] amount_q, amount_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [LW-1:0]    step_len;
    logic [DSIZE-1:0] mask_u, mask_s, top_u, top_s, work_step;
    logic [ASIZE-1:0] acc_step;
    logic             take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            ones_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            amount_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            ones_q      <= ones_d;
            zero_q      <= zero_d;
            out_data_q  <= out_data_d;
            amount_q    <= amount_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        acc_d      = acc_q;
        k_d        = k_q;
        mode_d     = mode_q;
        ones_d     = ones_q;
        zero_d     = zero_q;
        out_data_d = out_data_q;
        amount_d   = amount_q;

        // Step k examines the top 2**k bits (unsigned) or 2**k+1 bits (signed).
        step_len  = LW'(1) << k_q;
        mask_u    = ~({DSIZE{1'b1}} >> step_len);
        mask_s    = ~({DSIZE{1'b1}} >> (step_len + LW'(1)));
        top_u     = work_q & mask_u;
        top_s     = work_q & mask_s;
        take      = mode_q ? ((top_s == '0) || (top_s == mask_s)) : (top_u == '0);
        work_step = take ? (work_q << step_len) : work_q;
        acc_step  = take ? (acc_q | (ASIZE'(1) << k_q)) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_data;
                    mode_d  = mode;
                    ones_d  = mode && (&in_data);
                    zero_d  = (in_data == '0);
                    k_d     = KW'(ASIZE - 1);
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = work_step;
                acc_d  = acc_step;
                if (k_q == '0) begin
                    // A signed all-ones word is reported unchanged rather than zero-filled.
                    out_data_d = ones_q ? {DSIZE{1'b1}} : work_step;
                    amount_d   = acc_step;
                    state_d    = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign amount    = amount_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_normalizer_seq.sv
// Directed and randomized checks for normalizer_seq (64-bit data, 6-bit amount).
module tb_normalizer_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [5:0]  amount;
    logic        zero;

    int checks;
    int failures;

    normalizer_seq #(.DSIZE(64), .ASIZE(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .amount    (amount),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count leading zeros, or leading copies of the sign bit minus one.
    function automatic int ref_amount(input logic [63:0] d, input logic m);
        int n;
        n = 0;
        if (!m) begin
            for (int i = 63; i >= 0; i--) begin
                if (d[i]) break;
                n++;
            end
            if (n > 63) n = 63;
        end else begin
            for (int i = 62; i >= 0; i--) begin
                if (d[i] != d[63]) break;
                n++;
            end
        end
        return n;
    endfunction

    // One request/response with out_ready high; lat counts edges from accept (E0) to out_valid.
    task automatic run_op(input logic [63:0] d, input logic m,
                          output logic [63:0] od, output logic [5:0] oa,
                          output logic oz, output int lat);
        int n;
        n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        mode     = ~m;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        od = out_data;
        oa = amount;
        oz = zero;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== 64'h0 || amount !== 6'd0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: out_data=%h amount=%0d zero=%b required 0/0/0", out_data, amount, zero);
        end
    endtask

    task automatic test_unsigned();
        logic [63:0] od; logic [5:0] oa; logic oz; int lat;
        run_op(64'h0000_0000_0000_0001, 1'b0, od, oa, oz, lat);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL u_latency: got %0d edges required 7", lat);
        end
        checks++;
        if (oa !== 6'd63 || od !== 64'h8000_0000_0000_0000 || oz !== 1'b0) begin
            failures++;
            $display("FAIL u_one: amount=%0d data=%h zero=%b required 63/8000000000000000/0", oa, od, oz);
        end
        run_op(64'h00F0_0000_0000_0000, 1'b0, od, oa, oz, lat);
        checks++;
        if (oa !== 6'd8 || od !== 64'hF000_0000_0000_0000) begin
            failures++;
            $display("FAIL u_f0: amount=%0d data=%h required 8/f000000000000000", oa, od);
        end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, od, oa, oz, lat);
        checks++;
        if (oa !== 6'd0 || od !== 64'hFFFF_FFFF_FFFF_FFFF || oz !== 1'b0) begin
            failures++;
            $display("FAIL u_ones: amount=%0d data=%h zero=%b required 0/ffffffffffffffff/0", oa, od, oz);
        end
    endtask

    task automatic test_signed();
        logic [63:0] od; logic [5:0] oa; logic oz; int lat;
        run_op(64'hFFFF_FFFF_FFFF_FF80, 1'b1, od, oa, oz, lat);
        checks++;
        if (oa !== 6'd56 || od !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL s_neg: amount=%0d data=%h required 56/8000000000000000", oa, od);
        end
        run_op(64'h0000_0000_0000_0001, 1'b1, od, oa, oz, lat);
        checks++;
        if (oa !== 6'd62 || od !== 64'h4000_0000_0000_0000) begin
            failures++;
            $display("FAIL s_one: amount=%0d data=%h required 62/4000000000000000", oa, od);
        end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, od, oa, oz, lat);
        checks++;
        if (oa !== 6'd63 || od !== 64'hFFFF_FFFF_FFFF_FFFF || oz !== 1'b0) begin
            failures++;
            $display("FAIL s_ones: amount=%0d data=%h zero=%b required 63/ffffffffffffffff/0", oa, od, oz);
        end
    endtask

    task automatic test_zero();
        logic [63:0] od; logic [5:0] oa; logic oz; int lat;
        for (int m = 0; m < 2; m++) begin
            run_op(64'h0, 1'(m), od, oa, oz, lat);
            checks++;
            if (oa !== 6'd63 || od !== 64'h0 || oz !== 1'b1) begin
                failures++;
                $display("FAIL zero_m%0d: amount=%0d data=%h zero=%b required 63/0/1", m, oa, od, oz);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] hd; logic [5:0] ha; int n; logic ok;
        n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 64'h00F0_0000_0000_0000; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 64'h0000_FFFF_0000_0000;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        hd = out_data; ha = amount;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== hd || amount !== ha || in_ready !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok || ha !== 6'd8 || hd !== 64'hF000_0000_0000_0000) begin
            failures++;
            $display("FAIL bp_hold: stable=%b amount=%0d data=%h required 1/8/f000000000000000", ok, ha, hd);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_pop: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept2: in_ready=%b required 0", in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (amount !== 6'd16 || out_data !== 64'hFFFF_0000_0000_0000) begin
            failures++;
            $display("FAIL bp_second: amount=%0d data=%h required 16/ffff000000000000", amount, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] od; logic [5:0] oa; logic oz; int lat; logic seen;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = 64'h0000_0000_0000_0001; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0 || amount !== 6'd0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b data=%h amount=%0d zero=%b required 1/0/0/0/0",
                     in_ready, out_valid, out_data, amount, zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_discard: stale result or in_ready low seen=%b required 0", seen);
        end
        run_op(64'h8000_0000_0000_0000, 1'b0, od, oa, oz, lat);
        checks++;
        if (oa !== 6'd0 || od !== 64'h8000_0000_0000_0000 || lat !== 7) begin
            failures++;
            $display("FAIL rst_fresh: amount=%0d data=%h lat=%0d required 0/8000000000000000/7", oa, od, lat);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, nres;
        logic [5:0] res_amt [2];
        a0 = -1; a1 = -1; nres = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = 64'h0000_0000_0000_0001; mode = 1'b0; in_valid = 1'b1;
        for (int e = 0; e < 30; e++) begin
            logic acc;
            if (e > 0) @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                if (a0 < 0) a0 = e; else a1 = e;
            end
            @(posedge clk); #1;
            if (acc && a1 < 0) begin
                in_data = 64'hFFFF_FFFF_FFFF_FF80; mode = 1'b1;
            end else if (acc) begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1 && nres < 2) begin
                res_amt[nres] = amount;
                nres++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (a1 - a0 !== 8) begin
            failures++;
            $display("FAIL b2b_spacing: accepts %0d cycles apart required 8", a1 - a0);
        end
        checks++;
        if (nres !== 2 || res_amt[0] !== 6'd63 || res_amt[1] !== 6'd56) begin
            failures++;
            $display("FAIL b2b_results: n=%0d amounts=%0d,%0d required 2/63,56", nres, res_amt[0], res_amt[1]);
        end
    endtask

    task automatic test_random();
        for (int op = 0; op < 3000; op++) begin
            logic [63:0] d, exp_d;
            logic        m;
            int          ea, n;
            m = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (m && $urandom_range(0, 1) == 1) d = ~d;
            ea = ref_amount(d, m);
            exp_d = (m && d == 64'hFFFF_FFFF_FFFF_FFFF) ? d : (d << ea);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            in_data = d; mode = m; in_valid = 1'b1;
            n = 0;
            while (in_ready !== 1'b1 && n < 50) begin
                @(negedge clk); n++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = {$urandom, $urandom}; mode = ~m;
            n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || amount !== 6'(ea) || out_data !== exp_d) begin
                failures++;
                $display("FAIL rand_op%0d: in=%h mode=%b valid=%b amount=%0d data=%h required amount=%0d data=%h",
                         op, d, m, out_valid, amount, out_data, ea, exp_d);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        mode      = 1'b0;
        out_ready = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_unsigned();
        test_signed();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
